// File: rtl/instr_sequencer.sv
// Control sequencer for the single-bus datapath: fetch over PC/MAR/MDR/IR,
// decode from IR, then drive register selects and bus/latch strobes per step.
module instr_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int OPCODE_W   = 5,
    parameter int REG_SEL_W  = 4,
    parameter int NUM_REGS   = 16
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  run,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] ir,
    output logic                  PCout,
    output logic                  PCin,
    output logic                  IncPC,
    output logic                  MARin,
    output logic                  Read,
    output logic                  MDRin,
    output logic                  MDRout,
    output logic                  IRin,
    output logic                  Yin,
    output logic                  ZLowIn,
    output logic                  ZHighIn,
    output logic                  ZLowOut,
    output logic                  ZHighOut,
    output logic                  LOin,
    output logic                  HIin,
    output logic [OPCODE_W-1:0]   alu_op,
    output logic [NUM_REGS-1:0]   Rout,
    output logic [NUM_REGS-1:0]   Rin,
    output logic [3:0]            step,
    output logic                  halted,
    output logic                  illegal_op
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8
    } state_t;

    localparam int LOW_W = DATA_WIDTH - OPCODE_W - 3 * REG_SEL_W;
    localparam int unsigned NR = NUM_REGS;

    state_t state, state_next;

    logic [OPCODE_W-1:0]  opcode;
    logic [REG_SEL_W-1:0] ra, rb, rc;
    logic is_alu, is_mul, is_div, is_muldiv, is_nop, is_halt, is_ill, uses_regs;
    logic ra_ok, rb_ok, rc_ok, bad_regs;

    assign opcode = ir[DATA_WIDTH-1 -: OPCODE_W];
    assign ra     = ir[DATA_WIDTH-OPCODE_W-1 -: REG_SEL_W];
    assign rb     = ir[DATA_WIDTH-OPCODE_W-REG_SEL_W-1 -: REG_SEL_W];
    assign rc     = ir[DATA_WIDTH-OPCODE_W-2*REG_SEL_W-1 -: REG_SEL_W];

    generate
        if (LOW_W > 0) begin : g_low
            logic unused_low;
            assign unused_low = ^ir[LOW_W-1:0];
        end
    endgenerate

    assign is_alu    = (opcode >= OPCODE_W'(3)) && (opcode <= OPCODE_W'(10));
    assign is_mul    = (opcode == OPCODE_W'(15));
    assign is_div    = (opcode == OPCODE_W'(16));
    assign is_nop    = (opcode == OPCODE_W'(26));
    assign is_halt   = (opcode == OPCODE_W'(27));
    assign is_muldiv = is_mul | is_div;
    assign uses_regs = is_alu | is_muldiv;
    assign is_ill    = ~(uses_regs | is_nop | is_halt);

    assign ra_ok    = 32'(ra) < NR;
    assign rb_ok    = 32'(rb) < NR;
    assign rc_ok    = 32'(rc) < NR;
    // ra is only a destination for ALU ops; MUL/DIV write LO/HI instead
    assign bad_regs = (is_alu & ~ra_ok) | (uses_regs & (~rb_ok | ~rc_ok));

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_W-1:0] idx);
        logic [NUM_REGS-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NR; i++)
            if (idx == REG_SEL_W'(i)) r[i] = 1'b1;
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (clear) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (clear)
            illegal_op <= 1'b0;
        else if (state == S_T3 && (is_ill || bad_regs))
            illegal_op <= 1'b1;
    end

    always_comb begin
        state_t end_next;
        end_next   = run ? S_T0 : S_IDLE;
        state_next = state;
        case (state)
            S_IDLE: state_next = run ? S_T0 : S_IDLE;
            S_T0:   state_next = S_T1;
            S_T1:   state_next = mem_ready ? S_T2 : S_T1;
            S_T2:   state_next = S_T3;
            S_T3:   state_next = uses_regs ? S_T4 : (is_halt ? S_HALT : end_next);
            S_T4:   state_next = S_T5;
            S_T5:   state_next = is_muldiv ? S_T6 : end_next;
            S_T6:   state_next = end_next;
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin} = '0;
        {Yin, ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOin, HIin} = '0;
        alu_op = '0;
        Rout   = '0;
        Rin    = '0;
        halted = 1'b0;
        step   = state;
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
            S_T1: begin ZLowOut = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: if (uses_regs) begin
                Rout = onehot(rb);
                Yin  = 1'b1;
            end
            S_T4: begin
                Rout    = onehot(rc);
                ZLowIn  = 1'b1;
                ZHighIn = is_muldiv;
                alu_op  = opcode;
            end
            S_T5: begin
                ZLowOut = 1'b1;
                LOin    = is_muldiv;
                if (is_alu) Rin = onehot(ra);
            end
            S_T6:   begin ZHighOut = 1'b1; HIin = 1'b1; end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule
